// File: rtl/frame_fsm_pkg.sv
// Shared encodings for the 5-state frame FSM and the tick lines that drive it.
package frame_fsm_pkg;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_CRC    = 3'd1;
   localparam logic [ST_W-1:0] ST_WRITE  = 3'd2;
   localparam logic [ST_W-1:0] ST_DECIDE = 3'd3;
   localparam logic [ST_W-1:0] ST_SEND   = 3'd4;

   localparam int N_TICKS = 6;

   typedef enum logic [2:0] {
      TK_START = 3'd0,
      TK_CRC   = 3'd1,
      TK_WRITE = 3'd2,
      TK_NEXT  = 3'd3,
      TK_IDLE  = 3'd4,
      TK_SEND  = 3'd5,
      TK_NONE  = 3'd6
   } tick_e;

endpackage

// File: rtl/phase_timer.sv
// Saturating cycle counter with synchronous clear; hit_o flags the cycle whose
// increment lands exactly on MAX, so it fires once per phase.
module phase_timer #(
   parameter int W   = 10,
   parameter int MAX = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      hit_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != W'(MAX))) begin
         cnt_d = cnt_q + W'(1);
         hit_o = (cnt_d == W'(MAX));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/frame_tick_sequencer.sv
// Turns requests and datapath status into registered single-cycle ticks for the
// frame FSM, counts frames per burst and watches for stalled phases.
module frame_tick_sequencer
   import frame_fsm_pkg::*;
#(
   parameter int NBR_FRAMES = 4,
   parameter int CNT_W      = 4,
   parameter int TIMEOUT    = 1023,
   parameter int TO_W       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       state_reg,
   input  logic             start_req,
   input  logic             send_req,
   input  logic             crc_done,
   input  logic             wr_ack,
   input  logic             send_done,
   output logic             tick_START,
   output logic             tick_CRC,
   output logic             tick_WRITE,
   output logic             tick_NEXT,
   output logic             tick_IDLE,
   output logic             tick_SEND,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy,
   output logic             req_dropped,
   output logic             err_timeout
);

   logic [N_TICKS-1:0] tick_q, tick_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [ST_W-1:0]    rec_state_q, rec_state_d;
   logic [ST_W-1:0]    prev_state_q;
   logic               armed_q, armed_d, armed_now;
   logic               busy_q, drop_q, drop_d, err_q, err_d;
   logic               start_q, send_q;
   logic               to_clr, to_hit;
   tick_e              sel;

   // Timer restarts on every state change and idles outside the timed states.
   assign to_clr = (state_reg == ST_IDLE) || (state_reg > ST_SEND) ||
                   (state_reg != prev_state_q);

   phase_timer #(
      .W   (TO_W),
      .MAX (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (to_clr),
      .en_i  (1'b1),
      .hit_o (to_hit)
   );

   always_comb begin
      sel         = TK_NONE;
      tick_d      = '0;
      drop_d      = 1'b0;
      err_d       = err_q;
      frame_cnt_d = frame_cnt_q;
      armed_now   = armed_q || (state_reg != rec_state_q);

      if (armed_now) begin
         case (state_reg)
            ST_IDLE: begin
               if (start_req) begin
                  sel         = TK_START;
                  frame_cnt_d = '0;
                  drop_d      = send_req;
               end else if (send_req) begin
                  sel = TK_SEND;
               end
            end
            ST_CRC:   if (crc_done) sel = TK_CRC;
            ST_WRITE: begin
               if (wr_ack) begin
                  sel = TK_WRITE;
                  if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
            ST_DECIDE: begin
               if (to_hit || (frame_cnt_q >= CNT_W'(NBR_FRAMES))) sel = TK_IDLE;
               else                                               sel = TK_NEXT;
            end
            ST_SEND:  if (send_done || to_hit) sel = TK_IDLE;
            default:  sel = TK_NONE;
         endcase
      end

      if ((state_reg != ST_IDLE) &&
          ((start_req && !start_q) || (send_req && !send_q))) drop_d = 1'b1;

      if (to_hit) err_d = 1'b1;
      if ((sel == TK_START) || (sel == TK_SEND)) err_d = 1'b0;

      if (sel != TK_NONE) begin
         tick_d[sel] = 1'b1;
         armed_d     = 1'b0;
         rec_state_d = state_reg;
      end else begin
         armed_d     = armed_now;
         rec_state_d = rec_state_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q       <= '0;
         frame_cnt_q  <= '0;
         rec_state_q  <= ST_IDLE;
         prev_state_q <= ST_IDLE;
         armed_q      <= 1'b1;
         busy_q       <= 1'b0;
         drop_q       <= 1'b0;
         err_q        <= 1'b0;
         start_q      <= 1'b0;
         send_q       <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         frame_cnt_q  <= frame_cnt_d;
         rec_state_q  <= rec_state_d;
         prev_state_q <= state_reg;
         armed_q      <= armed_d;
         busy_q       <= (state_reg != ST_IDLE);
         drop_q       <= drop_d;
         err_q        <= err_d;
         start_q      <= start_req;
         send_q       <= send_req;
      end
   end

   assign tick_START  = tick_q[TK_START];
   assign tick_CRC    = tick_q[TK_CRC];
   assign tick_WRITE  = tick_q[TK_WRITE];
   assign tick_NEXT   = tick_q[TK_NEXT];
   assign tick_IDLE   = tick_q[TK_IDLE];
   assign tick_SEND   = tick_q[TK_SEND];
   assign frame_cnt   = frame_cnt_q;
   assign busy        = busy_q;
   assign req_dropped = drop_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_frame_tick_sequencer.sv
// Directed bench: the bench plays the frame FSM, queues each expected tick when
// it drives the qualifying input, and a monitor pops the queue as ticks appear.
module tb_frame_tick_sequencer;

   localparam logic [5:0] E_START = 6'b000001;
   localparam logic [5:0] E_CRC   = 6'b000010;
   localparam logic [5:0] E_WRITE = 6'b000100;
   localparam logic [5:0] E_NEXT  = 6'b001000;
   localparam logic [5:0] E_IDLE  = 6'b010000;
   localparam logic [5:0] E_SEND  = 6'b100000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] state_reg = 3'd0;
   logic       start_req = 1'b0, send_req = 1'b0;
   logic       crc_done = 1'b0, wr_ack = 1'b0, send_done = 1'b0;
   logic       tick_START, tick_CRC, tick_WRITE, tick_NEXT, tick_IDLE, tick_SEND;
   logic [3:0] frame_cnt;
   logic       busy, req_dropped, err_timeout;

   int tests = 0;
   int fails = 0;
   logic [5:0] exp_q[$];

   frame_tick_sequencer #(
      .NBR_FRAMES (2),
      .CNT_W      (4),
      .TIMEOUT    (15),
      .TO_W       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .state_reg   (state_reg),
      .start_req   (start_req),
      .send_req    (send_req),
      .crc_done    (crc_done),
      .wr_ack      (wr_ack),
      .send_done   (send_done),
      .tick_START  (tick_START),
      .tick_CRC    (tick_CRC),
      .tick_WRITE  (tick_WRITE),
      .tick_NEXT   (tick_NEXT),
      .tick_IDLE   (tick_IDLE),
      .tick_SEND   (tick_SEND),
      .frame_cnt   (frame_cnt),
      .busy        (busy),
      .req_dropped (req_dropped),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ticks();
      return {tick_SEND, tick_IDLE, tick_NEXT, tick_WRITE, tick_CRC, tick_START};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (ticks() != 6'b0)) begin
         if (exp_q.size() == 0) chk("unexpected_tick", {26'b0, ticks()}, 32'h0);
         else                   chk("tick_seq", {26'b0, ticks()}, {26'b0, exp_q.pop_front()});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain_chk(input string tag);
      @(negedge clk);
      #1;
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic set_in(input int which, input logic v);
      case (which)
         0: crc_done  = v;
         1: wr_ack    = v;
         2: send_done = v;
         3: start_req = v;
         default: send_req = v;
      endcase
   endtask

   // Input returned 3 cycles into the phase, held one cycle, tick expected next edge.
   task automatic pulse_in(input int which, input logic [5:0] exp, input string tag);
      cyc(3);
      set_in(which, 1'b1);
      exp_q.push_back(exp);
      cyc(1);
      set_in(which, 1'b0);
      drain_chk(tag);
   endtask

   task automatic go_state(input logic [2:0] s);
      cyc(2);
      state_reg = s;
   endtask

   task automatic decide(input logic [5:0] exp, input string tag);
      go_state(3'd3);
      exp_q.push_back(exp);
      cyc(1);
      drain_chk(tag);
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk("rst_ticks", {26'b0, ticks()}, 32'h0);
      chk("rst_frame_cnt", {28'b0, frame_cnt}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_err", {31'b0, err_timeout}, 32'd0);
      chk("rst_drop", {31'b0, req_dropped}, 32'd0);
      rst = 1'b0;

      // Full burst of two frames
      pulse_in(3, E_START, "burst_start");
      go_state(3'd1);
      cyc(1);
      chk("busy_in_crc", {31'b0, busy}, 32'd1);
      pulse_in(0, E_CRC, "burst_crc0");
      go_state(3'd2);
      pulse_in(1, E_WRITE, "burst_write0");
      chk("frame_cnt_1", {28'b0, frame_cnt}, 32'd1);
      decide(E_NEXT, "burst_next");
      go_state(3'd1);
      pulse_in(0, E_CRC, "burst_crc1");
      go_state(3'd2);
      pulse_in(1, E_WRITE, "burst_write1");
      decide(E_IDLE, "burst_idle");
      chk("frame_cnt_2", {28'b0, frame_cnt}, 32'd2);
      go_state(3'd0);

      // Simultaneous start and send
      cyc(1);
      start_req = 1'b1;
      send_req  = 1'b1;
      exp_q.push_back(E_START);
      cyc(1);
      chk("both_drop", {31'b0, req_dropped}, 32'd1);
      chk("both_frame_cnt", {28'b0, frame_cnt}, 32'd0);
      start_req = 1'b0;
      send_req  = 1'b0;
      cyc(1);
      chk("both_drop_1cyc", {31'b0, req_dropped}, 32'd0);
      drain_chk("both_start");

      // Arm guard: crc_done held high across a long stay in state 1
      go_state(3'd1);
      cyc(1);
      crc_done = 1'b1;
      exp_q.push_back(E_CRC);
      cyc(6);
      drain_chk("guard_single_crc");
      start_req = 1'b1;
      cyc(1);
      chk("drop_start_in_crc", {31'b0, req_dropped}, 32'd1);
      start_req = 1'b0;
      state_reg = 3'd2;
      cyc(2);
      state_reg = 3'd1;
      exp_q.push_back(E_CRC);
      cyc(1);
      crc_done = 1'b0;
      drain_chk("guard_rearm_crc");

      // Timeout in state 2: flag only, then a late wr_ack still writes
      cyc(1);
      state_reg = 3'd2;
      cyc(15);
      chk("to_w_early", {31'b0, err_timeout}, 32'd0);
      cyc(1);
      chk("to_w_set", {31'b0, err_timeout}, 32'd1);
      drain_chk("to_w_no_tick");
      wr_ack = 1'b1;
      exp_q.push_back(E_WRITE);
      cyc(1);
      wr_ack = 1'b0;
      chk("to_w_frame_cnt", {28'b0, frame_cnt}, 32'd1);
      chk("to_w_sticky", {31'b0, err_timeout}, 32'd1);
      drain_chk("to_w_late_write");

      // Send clears the flag; timeout in state 4 forces tick_IDLE
      go_state(3'd0);
      pulse_in(4, E_SEND, "send_tick");
      chk("send_clears_err", {31'b0, err_timeout}, 32'd0);
      cyc(1);
      state_reg = 3'd4;
      cyc(14);
      exp_q.push_back(E_IDLE);
      cyc(1);
      chk("to_s_early", {31'b0, err_timeout}, 32'd0);
      cyc(1);
      chk("to_s_set", {31'b0, err_timeout}, 32'd1);
      drain_chk("to_s_idle");
      go_state(3'd0);
      cyc(3);
      chk("to_s_sticky", {31'b0, err_timeout}, 32'd1);
      pulse_in(3, E_START, "restart");
      chk("start_clears_err", {31'b0, err_timeout}, 32'd0);
      chk("restart_frame_cnt", {28'b0, frame_cnt}, 32'd0);

      // Reset mid-burst with frame_cnt=2 and the flag raised
      go_state(3'd1);
      pulse_in(0, E_CRC, "mid_crc0");
      go_state(3'd2);
      pulse_in(1, E_WRITE, "mid_write0");
      decide(E_NEXT, "mid_next");
      go_state(3'd1);
      pulse_in(0, E_CRC, "mid_crc1");
      go_state(3'd2);
      pulse_in(1, E_WRITE, "mid_write1");
      cyc(17);
      chk("mid_frame_cnt", {28'b0, frame_cnt}, 32'd2);
      chk("mid_err", {31'b0, err_timeout}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_ticks", {26'b0, ticks()}, 32'h0);
      chk("async_frame_cnt", {28'b0, frame_cnt}, 32'd0);
      chk("async_err", {31'b0, err_timeout}, 32'd0);
      chk("async_busy", {31'b0, busy}, 32'd0);
      state_reg = 3'd0;
      cyc(2);
      rst = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
